// File: rtl/cdr_pkg.sv
// Shared types and default constants for the CDR lock controller and its window judge.
package cdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } cdr_state_t;

    localparam int DEF_WIN_LOG2    = 6;
    localparam int DEF_LOCK_THR    = 8;
    localparam int DEF_MIN_TRANS   = 8;
    localparam int DEF_LOCK_WINS   = 4;
    localparam int DEF_UNLOCK_WINS = 2;
    localparam int DEF_LOS_CYCLES  = 255;

    localparam int DEF_ACQ_KP = 2;
    localparam int DEF_ACQ_KI = 4;
    localparam int DEF_TRK_KP = 4;
    localparam int DEF_TRK_KI = 8;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdr_lock_window.sv
// Accumulates phase-detector balance and transition count over a 2^WIN_LOG2-bit window
// and judges the window on its final sample.
module cdr_lock_window
    import cdr_pkg::*;
#(
    parameter int WIN_LOG2  = DEF_WIN_LOG2,
    parameter int LOCK_THR  = DEF_LOCK_THR,
    parameter int MIN_TRANS = DEF_MIN_TRANS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample_en,
    input  logic pd_early,
    input  logic pd_late,
    output logic win_done,
    output logic win_good
);

    localparam int BAL_W = WIN_LOG2 + 2;
    localparam int TRN_W = WIN_LOG2 + 1;

    logic [WIN_LOG2-1:0]     smp_cnt;
    logic signed [BAL_W-1:0] bal;
    logic signed [BAL_W-1:0] bal_sum;
    logic signed [BAL_W-1:0] step;
    logic [BAL_W-1:0]        bal_mag;
    logic [TRN_W-1:0]        trans;
    logic [TRN_W-1:0]        trans_sum;
    logic                    is_trans;

    // The window-end sample is folded into the sums before judging.
    always_comb begin
        step     = '0;
        is_trans = sample_en && (pd_early || pd_late);
        if (sample_en && pd_early && !pd_late) begin
            step = BAL_W'(1);
        end else if (sample_en && pd_late && !pd_early) begin
            step = '1;
        end
        bal_sum   = bal + step;
        trans_sum = trans + {{(TRN_W-1){1'b0}}, is_trans};
        bal_mag   = bal_sum[BAL_W-1] ? -bal_sum : bal_sum;
        win_done  = sample_en && (smp_cnt == '1);
        win_good  = win_done
                    && (bal_mag <= BAL_W'(LOCK_THR))
                    && (trans_sum >= TRN_W'(MIN_TRANS));
    end

    always_ff @(posedge clk) begin
        if (rst || clr || win_done) begin
            smp_cnt <= '0;
            bal     <= '0;
            trans   <= '0;
        end else if (sample_en) begin
            smp_cnt <= smp_cnt + WIN_LOG2'(1);
            bal     <= bal_sum;
            trans   <= trans_sum;
        end
    end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// CDR lock-acquisition FSM: judges lock over bit windows, schedules loop-filter gains,
// detects loss of signal and drives the integrator clear/freeze controls.
module cdr_lock_ctrl
    import cdr_pkg::*;
#(
    parameter int WIN_LOG2    = DEF_WIN_LOG2,
    parameter int LOCK_THR    = DEF_LOCK_THR,
    parameter int MIN_TRANS   = DEF_MIN_TRANS,
    parameter int LOCK_WINS   = DEF_LOCK_WINS,
    parameter int UNLOCK_WINS = DEF_UNLOCK_WINS,
    parameter int LOS_CYCLES  = DEF_LOS_CYCLES,
    parameter int ACQ_KP      = DEF_ACQ_KP,
    parameter int ACQ_KI      = DEF_ACQ_KI,
    parameter int TRK_KP      = DEF_TRK_KP,
    parameter int TRK_KI      = DEF_TRK_KI
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sample_en,
    input  logic       pd_early,
    input  logic       pd_late,
    output logic [3:0] kp_shift,
    output logic [3:0] ki_shift,
    output logic       acc_clr,
    output logic       freeze,
    output logic       lock,
    output logic [1:0] state
);

    localparam int RUN_W = cnt_width((LOCK_WINS > UNLOCK_WINS) ? LOCK_WINS : UNLOCK_WINS);

    cdr_state_t       state_r;
    cdr_state_t       state_d;
    logic [RUN_W-1:0] good_cnt;
    logic [RUN_W-1:0] good_cnt_d;
    logic [RUN_W-1:0] bad_cnt;
    logic [RUN_W-1:0] bad_cnt_d;
    logic [7:0]       los_cnt;
    logic [7:0]       los_cnt_d;
    logic             is_trans;
    logic             los_hit;
    logic             win_clr;
    logic             win_done;
    logic             win_good;

    assign is_trans = sample_en && (pd_early || pd_late);
    assign state    = state_r;

    cdr_lock_window #(
        .WIN_LOG2  (WIN_LOG2),
        .LOCK_THR  (LOCK_THR),
        .MIN_TRANS (MIN_TRANS)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .clr       (win_clr),
        .sample_en (sample_en),
        .pd_early  (pd_early),
        .pd_late   (pd_late),
        .win_done  (win_done),
        .win_good  (win_good)
    );

    // LOS only runs while the loop is actively steering; IDLE and HOLD keep it at zero.
    always_comb begin
        los_hit   = 1'b0;
        los_cnt_d = '0;
        if ((state_r == ST_ACQ) || (state_r == ST_TRACK)) begin
            if (is_trans) begin
                los_cnt_d = '0;
            end else if (los_cnt == 8'(LOS_CYCLES - 1)) begin
                los_hit   = 1'b1;
                los_cnt_d = '0;
            end else begin
                los_cnt_d = los_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_r;
        good_cnt_d = good_cnt;
        bad_cnt_d  = bad_cnt;
        if (!ena) begin
            state_d = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if (los_hit) begin
                        state_d = ST_HOLD;
                    end else if (win_done) begin
                        if (!win_good) begin
                            good_cnt_d = '0;
                        end else if (good_cnt == RUN_W'(LOCK_WINS - 1)) begin
                            state_d = ST_TRACK;
                        end else begin
                            good_cnt_d = good_cnt + RUN_W'(1);
                        end
                    end
                end
                ST_TRACK: begin
                    if (los_hit) begin
                        state_d = ST_HOLD;
                    end else if (win_done) begin
                        if (win_good) begin
                            bad_cnt_d = '0;
                        end else if (bad_cnt == RUN_W'(UNLOCK_WINS - 1)) begin
                            state_d = ST_ACQ;
                        end else begin
                            bad_cnt_d = bad_cnt + RUN_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (is_trans) begin
                        state_d = ST_ACQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (state_d != state_r) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end
        win_clr = (state_r == ST_IDLE) || (state_r == ST_HOLD) || (state_d != state_r);
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            good_cnt <= '0;
            bad_cnt  <= '0;
            los_cnt  <= '0;
            lock     <= 1'b0;
            freeze   <= 1'b0;
            acc_clr  <= 1'b0;
            kp_shift <= 4'(ACQ_KP);
            ki_shift <= 4'(ACQ_KI);
        end else begin
            state_r  <= state_d;
            good_cnt <= good_cnt_d;
            bad_cnt  <= bad_cnt_d;
            los_cnt  <= los_cnt_d;
            lock     <= (state_d == ST_TRACK);
            freeze   <= (state_d == ST_HOLD);
            acc_clr  <= (state_r == ST_IDLE) && (state_d == ST_ACQ);
            kp_shift <= (state_d == ST_TRACK) ? 4'(TRK_KP) : 4'(ACQ_KP);
            ki_shift <= (state_d == ST_TRACK) ? 4'(TRK_KI) : 4'(ACQ_KI);
        end
    end

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Self-checking bench for cdr_lock_ctrl: directed scenarios plus random traffic,
// every cycle compared against a sample-queue reference model.
module tb_cdr_lock_ctrl;

    localparam int WIN   = 64;
    localparam int THR   = 8;
    localparam int MINT  = 8;
    localparam int LWINS = 4;
    localparam int UWINS = 2;
    localparam int LOS   = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       sample_en;
    logic       pd_early;
    logic       pd_late;
    logic [3:0] kp_shift;
    logic [3:0] ki_shift;
    logic       acc_clr;
    logic       freeze;
    logic       lock;
    logic [1:0] state;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: states as plain numbers, the open window as a list of samples.
    int     mState;
    bit     mAccClr;
    int     winBal[$];
    int     winTr[$];
    int     goodRun;
    int     badRun;
    longint cyc;
    longint quietStart;

    always #10 clk = ~clk;

    cdr_lock_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .sample_en (sample_en),
        .pd_early  (pd_early),
        .pd_late   (pd_late),
        .kp_shift  (kp_shift),
        .ki_shift  (ki_shift),
        .acc_clr   (acc_clr),
        .freeze    (freeze),
        .lock      (lock),
        .state     (state)
    );

    function automatic void modelReset();
        mState = 0;
        mAccClr = 1'b0;
        winBal.delete();
        winTr.delete();
        goodRun = 0;
        badRun = 0;
        quietStart = cyc + 1;
    endfunction

    function automatic void modelStep(input bit r, input bit en, input bit se, input bit e, input bit l);
        int nxt;
        bit trans;
        bit active;
        bit losHit;
        bit winEnd;
        bit good;
        int curB;
        int sumBal;
        int sumTr;
        if (r) begin
            modelReset();
            cyc++;
            return;
        end
        trans  = se && (e || l);
        active = (mState == 1) || (mState == 2);
        curB   = (se && e && !l) ? 1 : ((se && l && !e) ? -1 : 0);
        losHit = active && !trans && ((cyc - quietStart + 1) == LOS);
        winEnd = active && se && (winBal.size() == WIN - 1);
        sumBal = curB;
        sumTr  = trans ? 1 : 0;
        if (winEnd) begin
            foreach (winBal[i]) begin
                sumBal += winBal[i];
                sumTr  += winTr[i];
            end
        end
        good = ((sumBal < 0 ? -sumBal : sumBal) <= THR) && (sumTr >= MINT);
        nxt = mState;
        if (!en) nxt = 0;
        else if (mState == 0) nxt = 1;
        else if (mState == 3) begin
            if (trans) nxt = 1;
        end else if (losHit) nxt = 3;
        else if (winEnd) begin
            if (mState == 1) begin
                goodRun = good ? goodRun + 1 : 0;
                if (goodRun == LWINS) nxt = 2;
            end else begin
                badRun = good ? 0 : badRun + 1;
                if (badRun == UWINS) nxt = 1;
            end
        end
        if (nxt != mState || !active || winEnd) begin
            winBal.delete();
            winTr.delete();
        end else if (se) begin
            winBal.push_back(curB);
            winTr.push_back(trans ? 1 : 0);
        end
        if (nxt != mState) begin
            goodRun = 0;
            badRun = 0;
        end
        if (!active || trans || losHit) quietStart = cyc + 1;
        mAccClr = (mState == 0) && (nxt == 1);
        mState = nxt;
        cyc++;
    endfunction

    function automatic logic [12:0] modelOut();
        logic [1:0] s;
        s = 2'(mState);
        return {s, (mState == 2) ? 1'b1 : 1'b0, (mState == 3) ? 1'b1 : 1'b0, mAccClr,
                (mState == 2) ? 4'd4 : 4'd2, (mState == 2) ? 4'd8 : 4'd4};
    endfunction

    task automatic checkOutput(input string tag);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {state, lock, freeze, acc_clr, kp_shift, ki_shift};
        exp = modelOut();
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkExpect(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit en, input bit se, input bit e, input bit l);
        rst = r;
        ena = en;
        sample_en = se;
        pd_early = e;
        pd_late = l;
        @(posedge clk);
        modelStep(r, en, se, e, l);
        #1;
        checkOutput("model");
    endtask

    task automatic sendSample(input bit e, input bit l, input int gap);
        for (int i = 1; i < gap; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, e, l);
    endtask

    task automatic quietCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0);
    endtask

    // mode 0: alternate early/late, 1: early only, 2: no decision
    task automatic runPattern(input int n, input int mode, input int gap);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       sendSample((i % 2) == 0, (i % 2) == 1, gap);
                1:       sendSample(1, 0, gap);
                default: sendSample(0, 0, gap);
            endcase
        end
    endtask

    // One full window with the given mix, in random order and with random spacing.
    task automatic runWindow(input int nE, input int nL, input int nB, input int maxGap);
        int codes[WIN];
        for (int i = 0; i < WIN; i++) begin
            codes[i] = (i < nE) ? 1 : (i < nE + nL) ? 2 : (i < nE + nL + nB) ? 3 : 0;
        end
        for (int i = WIN - 1; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = codes[i];
            codes[i] = codes[j];
            codes[j] = t;
        end
        for (int i = 0; i < WIN; i++) begin
            sendSample(codes[i] == 1 || codes[i] == 3, codes[i] == 2 || codes[i] == 3,
                       int'($urandom_range(maxGap, 1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        sample_en = 1'b0;
        pd_early = 1'b0;
        pd_late = 1'b0;
        cyc = 0;
        modelReset();

        // Reset and enable
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        checkExpect("reset_state", 8'(state), 8'd0);
        checkExpect("reset_kp", 8'(kp_shift), 8'd2);
        checkExpect("reset_ki", 8'(ki_shift), 8'd4);
        checkExpect("reset_lock", 8'(lock), 8'd0);
        checkExpect("reset_freeze", 8'(freeze), 8'd0);
        checkExpect("reset_acc_clr", 8'(acc_clr), 8'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkExpect("idle_hold", 8'(state), 8'd0);
        applyStimulus(0, 1, 0, 0, 0);
        checkExpect("enable_state", 8'(state), 8'd1);
        checkExpect("acc_clr_pulse", 8'(acc_clr), 8'd1);
        applyStimulus(0, 1, 0, 0, 0);
        checkExpect("acc_clr_single", 8'(acc_clr), 8'd0);

        // Acquire with balanced alternating decisions
        runPattern(255, 0, 4);
        checkExpect("acq_255", 8'(state), 8'd1);
        sendSample(0, 1, 4);
        checkExpect("acq_track_state", 8'(state), 8'd2);
        checkExpect("acq_lock", 8'(lock), 8'd1);
        checkExpect("acq_kp", 8'(kp_shift), 8'd4);
        checkExpect("acq_ki", 8'(ki_shift), 8'd8);

        // Unlock with a one-sided phase error
        runPattern(127, 1, 4);
        checkExpect("unlock_127", 8'(state), 8'd2);
        sendSample(1, 0, 4);
        checkExpect("unlock_state", 8'(state), 8'd1);
        checkExpect("unlock_lock", 8'(lock), 8'd0);
        checkExpect("unlock_kp", 8'(kp_shift), 8'd2);
        checkExpect("unlock_no_clr", 8'(acc_clr), 8'd0);

        // Threshold edges: 3 good, 1 bad (bal -9), 4 good -> lock only after window 8
        runWindow(36, 28, 0, 3);
        runWindow(36, 28, 0, 3);
        runWindow(28, 36, 0, 3);
        checkExpect("thr_after3", 8'(state), 8'd1);
        runWindow(27, 36, 1, 3);
        runWindow(36, 28, 0, 3);
        runWindow(4, 4, 0, 2);
        runWindow(32, 32, 0, 3);
        checkExpect("thr_after7", 8'(state), 8'd1);
        runWindow(36, 28, 0, 3);
        checkExpect("thr_after8", 8'(state), 8'd2);
        runWindow(4, 3, 0, 2);
        checkExpect("trans7_bad_once", 8'(state), 8'd2);
        runWindow(32, 32, 0, 3);
        runWindow(4, 3, 0, 2);
        checkExpect("bad_cnt_cleared", 8'(state), 8'd2);

        // Loss of signal in TRACK
        sendSample(1, 0, 1);
        quietCycles(254);
        checkExpect("los_254", 8'(state), 8'd2);
        quietCycles(1);
        checkExpect("los_state", 8'(state), 8'd3);
        checkExpect("los_freeze", 8'(freeze), 8'd1);
        checkExpect("los_lock", 8'(lock), 8'd0);
        checkExpect("los_kp", 8'(kp_shift), 8'd2);
        quietCycles(5);
        applyStimulus(0, 1, 1, 0, 0);
        checkExpect("hold_stays", 8'(state), 8'd3);
        applyStimulus(0, 1, 1, 1, 0);
        checkExpect("hold_exit_state", 8'(state), 8'd1);
        checkExpect("hold_exit_freeze", 8'(freeze), 8'd0);

        // LOS terminal count on the same cycle as a window end
        applyStimulus(0, 1, 1, 1, 0);
        quietCycles(192);
        for (int i = 0; i < 62; i++) applyStimulus(0, 1, 1, 0, 0);
        checkExpect("los_win_pre", 8'(state), 8'd1);
        applyStimulus(0, 1, 1, 0, 0);
        checkExpect("los_beats_window", 8'(state), 8'd3);
        applyStimulus(0, 1, 1, 0, 1);

        // Abort paths
        runPattern(256, 0, 3);
        checkExpect("reacq_track", 8'(state), 8'd2);
        applyStimulus(0, 0, 0, 0, 0);
        checkExpect("ena_abort_state", 8'(state), 8'd0);
        checkExpect("ena_abort_lock", 8'(lock), 8'd0);
        applyStimulus(0, 1, 0, 0, 0);
        runPattern(39, 0, 4);
        applyStimulus(1, 1, 1, 1, 0);
        checkExpect("rst_mid_state", 8'(state), 8'd0);
        checkExpect("rst_mid_kp", 8'(kp_shift), 8'd2);
        applyStimulus(0, 1, 0, 0, 0);
        runPattern(255, 0, 4);
        checkExpect("full_window_needed", 8'(state), 8'd1);
        sendSample(0, 1, 4);
        checkExpect("relock", 8'(state), 8'd2);

        // Random traffic in segments of differing character
        for (int seg = 0; seg < 12; seg++) begin
            int mode;
            mode = int'($urandom_range(3, 0));
            for (int i = 0; i < 256; i++) begin
                bit se;
                bit e;
                bit l;
                bit r;
                bit en;
                se = ($urandom_range(2, 0) == 0);
                r  = ($urandom_range(999, 0) == 0);
                en = !((mode == 3) && ($urandom_range(199, 0) == 0));
                case (mode)
                    1: begin
                        e = ($urandom_range(9, 0) < 7);
                        l = !e;
                    end
                    2: begin
                        e = ($urandom_range(63, 0) == 0);
                        l = 1'b0;
                    end
                    default: begin
                        e = $urandom_range(1, 0) == 1;
                        l = ($urandom_range(7, 0) == 0) ? e : !e;
                    end
                endcase
                applyStimulus(r, en, se, e, l);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cdr_lock_ctrl.md
# cdr_lock_ctrl

Lock-acquisition and gain-scheduling controller for the CDR loop (`tt_um_sfg_cdr` datapath). It watches the phase detector's early/late decisions once per recovered bit (`sample_en`) and judges lock over fixed bit windows. It switches loop-filter gains between acquisition and tracking, and clears or freezes the loop-filter integrator. It also drives the lock indication exported on the TinyTapeout outputs.

## Interface
Parameters:
- `WIN_LOG2`, 6: window length is 2^WIN_LOG2 sampled bits (64).
- `LOCK_THR`, 8: maximum |early − late| for a good window.
- `MIN_TRANS`, 8: minimum transitions (early or late) for a good window.
- `LOCK_WINS`, 4: consecutive good windows needed to declare lock.
- `UNLOCK_WINS`, 2: consecutive bad windows that drop lock.
- `LOS_CYCLES`, 255: clk cycles with no transition before loss-of-signal; 8-bit counter.
- `ACQ_KP`, 2 and `ACQ_KI`, 4: proportional and integral shifts used in IDLE, ACQ and HOLD.
- `TRK_KP`, 4 and `TRK_KI`, 8: proportional and integral shifts used in TRACK.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: block enable; 0 forces IDLE.
- `sample_en` in 1: one-cycle pulse per recovered bit.
- `pd_early` in 1: early decision, qualified by `sample_en`.
- `pd_late` in 1: late decision, qualified by `sample_en`.
- `kp_shift` out 4: proportional gain shift to the loop filter.
- `ki_shift` out 4: integral gain shift to the loop filter.
- `acc_clr` out 1: one-cycle integrator clear.
- `freeze` out 1: hold the integrator.
- `lock` out 1: lock indication.
- `state` out 2: FSM state (IDLE=0, ACQ=1, TRACK=2, HOLD=3).

## Operation
- Transition: a `sample_en` cycle with `pd_early|pd_late` set.
  - Balance contribution: +1 for early only, −1 for late only, 0 for both.
  - Both set still counts as one transition.
- Window accumulator:
  - Counts `sample_en` pulses.
  - Holds a signed balance, WIN_LOG2+2 bits.
  - Holds a transition count, WIN_LOG2+1 bits.
- Window end is the cycle of the 2^WIN_LOG2-th `sample_en`. That sample is included in the evaluation.
  - good = (|bal| ≤ LOCK_THR) and (trans ≥ MIN_TRANS).
  - Accumulators restart at 0 on the same cycle.
- IDLE: gains are ACQ, lock=0, freeze=0, accumulators and counters held at 0.
  - `ena`=1 → ACQ, with `acc_clr` pulsed for exactly one cycle on entry.
- ACQ: a good window increments `good_cnt`; a bad window zeroes it.
  - `good_cnt` reaching LOCK_WINS → TRACK.
- TRACK: lock=1, gains are TRK.
  - A bad window increments `bad_cnt`; a good window zeroes it.
  - `bad_cnt` reaching UNLOCK_WINS → ACQ, with no `acc_clr`.
- LOS: the cycle counter resets on every transition and counts in ACQ and TRACK only.
  - Reaching LOS_CYCLES → HOLD.
- HOLD: freeze=1, lock=0, gains are ACQ.
  - The first transition → ACQ; window, `good_cnt` and `bad_cnt` reset; freeze drops.
- Every state entry clears `good_cnt`, `bad_cnt` and the window accumulator.
- Priority, highest first: `rst` > `ena`=0 (→IDLE next cycle) > LOS timeout > window evaluation.
- `sample_en` with both pd inputs low adds to the window count only.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=0, `lock`=0, `freeze`=0, `acc_clr`=0.
  - `kp_shift`=ACQ_KP, `ki_shift`=ACQ_KI.
- Latency: the decision cycle is the window-end `sample_en`, the LOS terminal count, or the HOLD-exit transition.
  - `state`, `lock`, gains and `freeze` change on the clock edge that ends the decision cycle, so they are visible one cycle later.
- `acc_clr` is high during the first cycle that `state`=ACQ after leaving IDLE.
- `rst` asserted mid-operation: all registers return to reset values at the next edge. Partial windows are discarded.
- `sample_en` may assert on consecutive cycles. There is no minimum spacing.

## Structure
- Shared package `cdr_pkg` holds:
  - the state enum (IDLE/ACQ/TRACK/HOLD, 2-bit);
  - default gain constants;
  - the `WIN_LOG2`, `LOCK_THR` and `MIN_TRANS` defaults.
- Sub-module `cdr_lock_window`:
  - Holds the window counter, balance and transition accumulators.
  - Outputs: `win_done` and `win_good` (one-cycle pulses); input: `clr`.
- Top level `cdr_lock_ctrl` holds the FSM, the window counters, the LOS timer and output registers.
- Expected size: ~200 lines total.

## Test plan
1. Reset and enable:
   - Hold `rst` for 3 cycles → `state`=0, `kp_shift`=2, `ki_shift`=4, `lock`=0.
   - Set `ena`=1 → `acc_clr` high exactly 1 cycle, `state`=1.
2. Acquire:
   - Stimulus: `sample_en` every 4 clk, alternating early/late (bal=0, trans=64).
   - Expect: one cycle after the 256th sample, `state`=2, `lock`=1, `kp_shift`=4, `ki_shift`=8.
3. Unlock:
   - In TRACK, drive early on every sample for 128 samples (bal=64).
   - Expect: `state`=1, `lock`=0, `kp_shift`=2, no `acc_clr`.
4. Threshold edges:
   - Window with bal=+8 and trans=64 counts as good; bal=−9 counts as bad.
   - Sequence 3 good, 1 bad, 4 good → lock only after the 8th window.
   - A window with 7 transitions is bad.
5. Loss of signal:
   - In TRACK, 255 cycles with no pd → `state`=3, `freeze`=1, `lock`=0.
   - A single `pd_early` → ACQ next cycle, `freeze`=0, window restarted.
   - LOS coinciding with a window end → HOLD.
6. Abort:
   - `ena`=0 mid-TRACK → `state`=0 and `lock`=0 next cycle.
   - `rst` mid-ACQ at sample 40 → reset values.
   - The next acquisition needs a full 256 samples.
